// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, opcode constants and ALU op codes for the control path
package cpu_ctrl_pkg;
  localparam int OPC_W = 5;
  localparam int ALUOP_W = 5;
  typedef enum logic [2:0] {S_RST, T0, T1, T2, T3, T4, T5, HALT} state_e;
  typedef enum logic [2:0] {C_LDI, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL} iclass_e;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00011;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/stop inputs and datapath control strobes between sequencer and Datapath
interface control_unit_if;
  import cpu_ctrl_pkg::*;
  logic [31:0] IR;
  logic Stop;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, Rin, CONin, Out_Portin;
  logic Gra, Grb, Grc;
  logic IncPC, Read, Write;
  logic [ALUOP_W-1:0] ALUop;
  logic Run, Illegal;
  modport master(
    input IR, Stop,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, Rin, CONin, Out_Portin,
    output Gra, Grb, Grc, IncPC, Read, Write, ALUop, Run, Illegal
  );
  modport slave(
    output IR, Stop,
    input PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout,
    input MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, Rin, CONin, Out_Portin,
    input Gra, Grb, Grc, IncPC, Read, Write, ALUop, Run, Illegal
  );
endinterface

// File: rtl/control_unit_decode.sv
// ctrl_decode: maps opcode IR[31:27] to an instruction class
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output iclass_e          iclass
);
  always_comb iclass = opc == OP_LDI  ? C_LDI  :
                       opc == OP_IN   ? C_IN   :
                       opc == OP_OUT  ? C_OUT  :
                       opc == OP_MFHI ? C_MFHI :
                       opc == OP_MFLO ? C_MFLO :
                       opc == OP_NOP  ? C_NOP  :
                       opc == OP_HALT ? C_HALT : C_ILLEGAL;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving Datapath strobes (Clock, active-low sync Reset, bus)
module control_unit
  import cpu_ctrl_pkg::*;
(
  input logic Clock,
  input logic Reset,
  control_unit_if.master bus
);
  state_e state_q, state_d;
  iclass_e iclass;
  logic t3, unused_ir;
  assign unused_ir = ^bus.IR[26:0];
  ctrl_decode u_dec (.opc(bus.IR[31:27]), .iclass(iclass));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = T0;
      T0: state_d = T1;
      T1: state_d = T2;
      T2: state_d = T3;
      T3: state_d = iclass == C_LDI ? T4 : (iclass == C_HALT || bus.Stop) ? HALT : T0;
      T4: state_d = T5;
      T5: state_d = bus.Stop ? HALT : T0;
      HALT: state_d = HALT;
    endcase
  end
  always_ff @(posedge Clock) state_q <= !Reset ? S_RST : state_d;
  assign t3 = state_q == T3;
  always_comb begin
    bus.PCout = state_q == T0;
    bus.MARin = state_q == T0;
    bus.IncPC = state_q == T0;
    bus.Zin = state_q == T0 || state_q == T4;
    bus.Zlowout = state_q == T1 || state_q == T5;
    bus.PCin = state_q == T1;
    bus.Read = state_q == T1;
    bus.MDRin = state_q == T1;
    bus.MDRout = state_q == T2;
    bus.IRin = state_q == T2;
    bus.Grb = t3 && iclass == C_LDI;
    bus.BAout = t3 && iclass == C_LDI;
    bus.Yin = t3 && iclass == C_LDI;
    bus.InPortout = t3 && iclass == C_IN;
    bus.Rout = t3 && iclass == C_OUT;
    bus.Out_Portin = t3 && iclass == C_OUT;
    bus.HIout = t3 && iclass == C_MFHI;
    bus.LOout = t3 && iclass == C_MFLO;
    bus.Gra = (t3 && iclass inside {C_IN, C_OUT, C_MFHI, C_MFLO}) || state_q == T5;
    bus.Rin = (t3 && iclass inside {C_IN, C_MFHI, C_MFLO}) || state_q == T5;
    bus.Cout = state_q == T4;
    bus.ALUop = state_q == T4 ? ALU_ADD : '0;
    bus.Illegal = t3 && iclass == C_ILLEGAL;
    bus.Run = state_q inside {T0, T1, T2, T3, T4, T5};
    bus.Zhighout = 1'b0;
    bus.Write = 1'b0;
    bus.CONin = 1'b0;
    bus.Grc = 1'b0;
    bus.LOin = 1'b0;
    bus.HIin = 1'b0;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed checks of control_unit against an instruction-step reference model
module tb_control_unit;
  localparam int ILL = 0, RUN = 1, WRITE = 7, READ = 8, INCPC = 9, GRC = 10, GRB = 11, GRA = 12;
  localparam int OUTP = 13, CONIN = 14, RIN = 15, HIIN = 16, LOIN = 17, YIN = 18, IRIN = 19, MDRIN = 20;
  localparam int PCIN = 21, ZIN = 22, MARIN = 23, INP = 24, ROUT = 25, BAOUT = 26, COUT = 27;
  localparam int LOOUT = 28, HIOUT = 29, MDROUT = 30, ZHI = 31, ZLO = 32, PCOUT = 33;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  control_unit_if bus ();
  control_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;
  logic [33:0] outv;
  assign outv = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout, bus.Cout,
                 bus.BAout, bus.Rout, bus.InPortout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin,
                 bus.Yin, bus.LOin, bus.HIin, bus.Rin, bus.CONin, bus.Out_Portin, bus.Gra, bus.Grb,
                 bus.Grc, bus.IncPC, bus.Read, bus.Write, bus.ALUop, bus.Run, bus.Illegal};
  int n_cmp = 0;
  int n_bad = 0;
  bit m_rst = 1'b1;
  bit m_halt = 1'b0;
  int m_k = 0;
  function automatic int last_step(input logic [4:0] op);
    return op == 5'b00001 ? 5 : 3;
  endfunction
  function automatic logic [33:0] bits(input int a, input int b = -1, input int c = -1, input int d = -1, input int e = -1);
    logic [33:0] v;
    v = '0;
    v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction
  function automatic logic [33:0] expv();
    logic [33:0] v;
    logic [4:0] op;
    v = '0;
    op = bus.IR[31:27];
    if (m_rst || m_halt) return v;
    case (m_k)
      0: v = bits(PCOUT, MARIN, INCPC, ZIN);
      1: v = bits(ZLO, PCIN, READ, MDRIN);
      2: v = bits(MDROUT, IRIN);
      3: case (op)
        5'b00001: v = bits(GRB, BAOUT, YIN);
        5'b10110: v = bits(INP, GRA, RIN);
        5'b10111: v = bits(GRA, ROUT, OUTP);
        5'b11000: v = bits(HIOUT, GRA, RIN);
        5'b11001: v = bits(LOOUT, GRA, RIN);
        5'b11010, 5'b11011: v = '0;
        default: v = bits(ILL);
      endcase
      4: begin v = bits(COUT, ZIN); v[6:2] = 5'b00011; end
      5: v = bits(ZLO, GRA, RIN);
      default: v = '0;
    endcase
    v[RUN] = 1'b1;
    return v;
  endfunction
  task automatic tick(input logic [31:0] ir, input logic stop, input logic rst_n);
    bus.IR = ir;
    bus.Stop = stop;
    Reset = rst_n;
    @(posedge Clock);
    if (!rst_n) begin
      m_rst = 1'b1;
      m_halt = 1'b0;
    end else if (m_rst) begin
      m_rst = 1'b0;
      m_k = 0;
    end else if (!m_halt) begin
      if (m_k == last_step(ir[31:27])) begin
        m_k = 0;
        if (stop || ir[31:27] == 5'b11011) m_halt = 1'b1;
      end else m_k++;
    end
    @(negedge Clock);
  endtask
  task automatic do_reset(input logic [31:0] ir);
    tick(ir, 1'b0, 1'b0);
    tick(ir, 1'b0, 1'b1);
  endtask
  task automatic test_reset();
    logic [31:0] ir = 32'hB0800000;
    for (int i = 0; i < 2; i++) begin
      tick(ir, 1'b0, 1'b0);
      n_cmp++;
      if (outv !== 34'd0) begin n_bad++; $display("FAIL reset_hold cyc%0d got %h want 0", i, outv); end
    end
    tick(ir, 1'b0, 1'b1);
    n_cmp++;
    if (outv !== bits(PCOUT, MARIN, INCPC, ZIN, RUN)) begin n_bad++; $display("FAIL reset_t0 got %h want %h", outv, bits(PCOUT, MARIN, INCPC, ZIN, RUN)); end
    tick(ir, 1'b0, 1'b1);
    n_cmp++;
    if (outv !== bits(ZLO, PCIN, READ, MDRIN, RUN)) begin n_bad++; $display("FAIL reset_t1 got %h want %h", outv, bits(ZLO, PCIN, READ, MDRIN, RUN)); end
  endtask
  task automatic test_in();
    logic [31:0] ir = 32'hB0800000;
    do_reset(ir);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL in_cyc%0d got %h want %h", i, outv, expv()); end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (outv !== (i == 3 ? bits(INP, GRA, RIN, RUN) : bits(PCOUT, MARIN, INCPC, ZIN, RUN))) begin
          n_bad++; $display("FAIL in_step%0d got %h", i, outv);
        end
      end
      tick(ir, 1'b0, 1'b1);
    end
  endtask
  task automatic test_ldi();
    logic [31:0] ir = 32'h08800005;
    do_reset(ir);
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL ldi_cyc%0d got %h want %h", i, outv, expv()); end
      if (i == 4) begin
        n_cmp++;
        if (bus.ALUop !== 5'b00011) begin n_bad++; $display("FAIL ldi_aluop got %b want 00011", bus.ALUop); end
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.PCout !== 1'b1) begin n_bad++; $display("FAIL ldi_period got PCout=%b want 1", bus.PCout); end
      end
      tick(ir, 1'b0, 1'b1);
    end
  endtask
  task automatic test_halt();
    logic [31:0] ir = 32'hD8000000;
    do_reset(ir);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL halt_cyc%0d got %h want %h", i, outv, expv()); end
      if (i >= 4) begin
        n_cmp++;
        if (outv !== 34'd0) begin n_bad++; $display("FAIL halt_idle%0d got %h want 0", i, outv); end
      end
      tick(ir, 1'b0, 1'b1);
    end
    tick(ir, 1'b0, 1'b0);
    tick(ir, 1'b0, 1'b1);
    n_cmp++;
    if (outv !== bits(PCOUT, MARIN, INCPC, ZIN, RUN)) begin n_bad++; $display("FAIL halt_restart got %h", outv); end
  endtask
  task automatic test_stop();
    logic [31:0] ir = 32'hB0800000;
    logic s;
    do_reset(ir);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL stop_in_cyc%0d got %h want %h", i, outv, expv()); end
      s = m_k == 1;
      tick(ir, s, 1'b1);
    end
    ir = 32'h08800005;
    do_reset(ir);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL stop_ldi_cyc%0d got %h want %h", i, outv, expv()); end
      if (i == 5 || i == 6) begin
        n_cmp++;
        if ({bus.Gra, bus.Rin, bus.Run} !== (i == 5 ? 3'b111 : 3'b000)) begin
          n_bad++; $display("FAIL stop_ldi_step%0d got %b", i, {bus.Gra, bus.Rin, bus.Run});
        end
      end
      s = m_k >= 4;
      tick(ir, s, 1'b1);
    end
  endtask
  task automatic test_midfetch_illegal();
    logic [31:0] ir = 32'hF8000000;
    do_reset(ir);
    tick(ir, 1'b0, 1'b1);
    n_cmp++;
    if (outv !== expv()) begin n_bad++; $display("FAIL midfetch_t1 got %h want %h", outv, expv()); end
    tick(ir, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Read, bus.MDRin, bus.Run} !== 3'b000) begin n_bad++; $display("FAIL midfetch_rst got %b want 000", {bus.Read, bus.MDRin, bus.Run}); end
    tick(ir, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL illegal_cyc%0d got %h want %h", i, outv, expv()); end
      n_cmp++;
      if (bus.Illegal !== (i == 3)) begin n_bad++; $display("FAIL illegal_flag%0d got %b want %b", i, bus.Illegal, i == 3); end
      tick(ir, 1'b0, 1'b1);
    end
  endtask
  task automatic test_random();
    logic [4:0] ops[8] = '{5'b00001, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b00000};
    logic [31:0] ir = 32'hD0000000;
    logic s, r;
    do_reset(ir);
    for (int i = 0; i < 600; i++) begin
      n_cmp++;
      if (outv !== expv()) begin n_bad++; $display("FAIL rand_cyc%0d got %h want %h", i, outv, expv()); end
      if (m_k == 0 || m_halt || m_rst) begin
        ir = $urandom;
        if ($urandom_range(0, 5) != 0) ir[31:27] = ops[$urandom_range(0, 6)];
        if ($urandom_range(0, 7) == 0) ir[31:27] = 5'b11011;
      end
      s = $urandom_range(0, 7) == 0;
      r = m_halt ? $urandom_range(0, 2) != 0 : $urandom_range(0, 39) != 0;
      tick(ir, s, r);
    end
  endtask
  initial begin
    bus.IR = '0;
    bus.Stop = 1'b0;
    test_reset();
    test_in();
    test_ldi();
    test_halt();
    test_stop();
    test_midfetch_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
